id_ex_stage: RTL

//  ID/EX pipeline register directly upstream of ALU. Captures a decoded instruction, generates
//  the 4-bit ALUOp, extends the immediate, and forwards the EX/MEM and MEM/WB results into ALU

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/id_ex_stage_if.sv | 69 ++++++
 rtl/id_ex_stage_alu_ctrl_decode.sv | 48 ++++
 rtl/id_ex_stage.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_pkg
// Purpose  : Shared ALUOp codes, opcode/funct values and decode result type
//            for the ID/EX stage and its control decoder.
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  // ALUOp codes presented to the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;

  // Everything the stage needs to know about an instruction's class
  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;    // operand B comes from the extended immediate
    logic       sign_ext;   // immediate is sign-extended (else zero-extended)
    logic       rt_is_src;  // rt is read as a source operand
    logic       illegal;    // undecodable opcode or funct
  } dec_t;

  function automatic logic is_rtype(input logic [5:0] opcode);
    return opcode == OP_RTYPE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Interface : id_ex_stage_if
// Purpose   : Decode-side instruction bus, forwarding sources and ALU-side
//             outputs of the ID/EX pipeline register.
// Revision  : 1.0  initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int SIZE = 32
);
  // Decode side
  logic            in_valid;
  logic            in_ready;
  logic            stall;
  logic            flush;
  logic [5:0]      in_opcode;
  logic [5:0]      in_funct;
  logic [4:0]      in_rs;
  logic [4:0]      in_rt;
  logic [4:0]      in_rd;
  logic [SIZE-1:0] in_rs_val;
  logic [SIZE-1:0] in_rt_val;
  logic [15:0]     in_imm;
  logic            in_reg_write;
  logic            in_mem_read;
  logic            in_mem_write;

  // Forwarding sources
  logic            exmem_reg_write;
  logic [4:0]      exmem_rd;
  logic [SIZE-1:0] exmem_result;
  logic            memwb_reg_write;
  logic [4:0]      memwb_rd;
  logic [SIZE-1:0] memwb_result;

  // Execute side
  logic [3:0]      alu_op;
  logic [SIZE-1:0] alu_a;
  logic [SIZE-1:0] alu_b;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [SIZE-1:0] ex_store_data;
  logic            ex_illegal;
  logic            load_use_hazard;

  // Upstream driver / observer of the stage
  modport master (
    output in_valid, stall, flush, in_opcode, in_funct, in_rs, in_rt, in_rd,
           in_rs_val, in_rt_val, in_imm, in_reg_write, in_mem_read, in_mem_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  in_ready, alu_op, alu_a, alu_b, ex_valid, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, ex_illegal, load_use_hazard
  );

  // The pipeline stage itself
  modport slave (
    input  in_valid, stall, flush, in_opcode, in_funct, in_rs, in_rt, in_rd,
           in_rs_val, in_rt_val, in_imm, in_reg_write, in_mem_read, in_mem_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output in_ready, alu_op, alu_a, alu_b, ex_valid, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, ex_illegal, load_use_hazard
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_decode
// Purpose  : Combinational opcode/funct decode into ALUOp, immediate handling,
//            rt-source flag and illegal-instruction flag.
// Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  // Default to illegal; each recognised encoding overrides the whole record
  always_comb begin
    dec_o = '{alu_op: ALU_ILL, use_imm: 1'b0, sign_ext: 1'b0, rt_is_src: 1'b0, illegal: 1'b1};
    if (is_rtype(opcode_i)) begin
      // rt is read by every R-type, even one with an unknown funct
      dec_o.rt_is_src = 1'b1;
      case (funct_i)
        F_AND:         begin dec_o.alu_op = ALU_AND; dec_o.illegal = 1'b0; end
        F_OR:          begin dec_o.alu_op = ALU_OR;  dec_o.illegal = 1'b0; end
        F_ADD, F_ADDU: begin dec_o.alu_op = ALU_ADD; dec_o.illegal = 1'b0; end
        F_SUB, F_SUBU: begin dec_o.alu_op = ALU_SUB; dec_o.illegal = 1'b0; end
        default:       ;
      endcase
    end else begin
      case (opcode_i)
        OP_LW, OP_ADDI:
          dec_o = '{alu_op: ALU_ADD, use_imm: 1'b1, sign_ext: 1'b1, rt_is_src: 1'b0, illegal: 1'b0};
        OP_SW:
          dec_o = '{alu_op: ALU_ADD, use_imm: 1'b1, sign_ext: 1'b1, rt_is_src: 1'b1, illegal: 1'b0};
        // BEQ compares two registers, so B stays on rt
        OP_BEQ:
          dec_o = '{alu_op: ALU_SUB, use_imm: 1'b0, sign_ext: 1'b1, rt_is_src: 1'b1, illegal: 1'b0};
        OP_ANDI:
          dec_o = '{alu_op: ALU_AND, use_imm: 1'b1, sign_ext: 1'b0, rt_is_src: 1'b0, illegal: 1'b0};
        OP_ORI:
          dec_o = '{alu_op: ALU_OR,  use_imm: 1'b1, sign_ext: 1'b0, rt_is_src: 1'b0, illegal: 1'b0};
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register feeding the ALU: captures a decoded
//            instruction, registers ALUOp and extended immediate, forwards
//            EX/MEM and MEM/WB results into the operands and flags
//            load-use hazards.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  dec_t            dec_d;
  logic [SIZE-1:0] imm_ext_d;

  logic            valid_q;
  logic [3:0]      alu_op_q;
  logic            use_imm_q;
  logic            illegal_q;
  logic [4:0]      rs_q;
  logic [4:0]      rt_q;
  logic [4:0]      rd_q;
  logic [SIZE-1:0] rs_val_q;
  logic [SIZE-1:0] rt_val_q;
  logic [SIZE-1:0] imm_ext_q;
  logic            reg_write_q;
  logic            mem_read_q;
  logic            mem_write_q;

  logic [SIZE-1:0] fwd_a;
  logic [SIZE-1:0] fwd_b;

  // Decode of the instruction currently offered by the decode stage
  alu_ctrl_decode u_dec (
    .opcode_i (bus.in_opcode),
    .funct_i  (bus.in_funct),
    .dec_o    (dec_d)
  );

  // Extend the immediate before capture so EX sees a ready operand
  always_comb begin
    imm_ext_d = {{(SIZE-16){1'b0}}, bus.in_imm};
    if (dec_d.sign_ext) imm_ext_d = {{(SIZE-16){bus.in_imm[15]}}, bus.in_imm};
  end

  // Pipeline register: flush beats stall, stall beats capture/bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      alu_op_q    <= 4'b0000;
      use_imm_q   <= 1'b0;
      illegal_q   <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_ext_q   <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        alu_op_q    <= dec_d.alu_op;
        use_imm_q   <= dec_d.use_imm;
        illegal_q   <= dec_d.illegal;
        rs_q        <= bus.in_rs;
        rt_q        <= bus.in_rt;
        rd_q        <= bus.in_rd;
        rs_val_q    <= bus.in_rs_val;
        rt_val_q    <= bus.in_rt_val;
        imm_ext_q   <= imm_ext_d;
        // An illegal instruction must never write state downstream
        reg_write_q <= bus.in_reg_write & ~dec_d.illegal;
        mem_read_q  <= bus.in_mem_read  & ~dec_d.illegal;
        mem_write_q <= bus.in_mem_write & ~dec_d.illegal;
      end
    end
  end

  // Newest producer wins; r0 is hard-wired zero and never forwarded
  function automatic logic [SIZE-1:0] fwd_sel(
    input logic [4:0]      idx,
    input logic [SIZE-1:0] reg_val,
    input logic            ex_we,
    input logic [4:0]      ex_rd,
    input logic [SIZE-1:0] ex_res,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [SIZE-1:0] wb_res
  );
    if (ex_we && (ex_rd == idx) && (idx != 5'd0)) return ex_res;
    if (wb_we && (wb_rd == idx) && (idx != 5'd0)) return wb_res;
    return reg_val;
  endfunction

  // Forwarding muxes sit after the register so they track live EX/MEM, MEM/WB values
  always_comb begin
    fwd_a = fwd_sel(rs_q, rs_val_q, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                    bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
    fwd_b = fwd_sel(rt_q, rt_val_q, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                    bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
  end

  assign bus.in_ready      = ~bus.stall;
  assign bus.alu_op        = alu_op_q;
  assign bus.alu_a         = fwd_a;
  assign bus.alu_b         = use_imm_q ? imm_ext_q : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = valid_q & reg_write_q;
  assign bus.ex_mem_read   = valid_q & mem_read_q;
  assign bus.ex_mem_write  = valid_q & mem_write_q;
  assign bus.ex_illegal    = valid_q & illegal_q;

  // A load in EX whose destination is read by the instruction in decode
  assign bus.load_use_hazard = valid_q && mem_read_q && (rd_q != 5'd0) && bus.in_valid &&
                               ((rd_q == bus.in_rs) || ((rd_q == bus.in_rt) && dec_d.rt_is_src));

endmodule
`default_nettype wire
